// File: rtl/clk_div_detect.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | clk_div_detect: measures period/high width of a clk-synchronous divided  |
// | clock, locks after LOCK_N identical periods. Rev 1.0                     |
// +--------------------------------------------------------------------------+
module clk_div_detect #(
  parameter int CNT_W  = 8,
  parameter int LOCK_N = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_in,
  output logic [CNT_W-1:0] div_ratio,
  output logic [CNT_W-1:0] high_width,
  output logic             odd_ratio,
  output logic             duty_even,
  output logic             locked,
  output logic             err
);

  localparam int MATCH_W = $clog2(LOCK_N + 2);
  localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
  localparam logic [MATCH_W-1:0] LOCK_TGT = MATCH_W'(LOCK_N);

  typedef enum logic [1:0] {IDLE = 2'd0, MEAS = 2'd1, LOCKED = 2'd2} state_t;

  state_t             state_q, state_d;
  logic               s_q, s_d_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   hw_cur_q, hw_cur_d;
  logic [CNT_W-1:0]   prev_p_q, prev_p_d;
  logic [CNT_W-1:0]   prev_h_q, prev_h_d;
  logic               have_prev_q, have_prev_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [CNT_W-1:0]   div_ratio_q, div_ratio_d;
  logic [CNT_W-1:0]   high_width_q, high_width_d;
  logic               odd_q, odd_d;
  logic               duty_q, duty_d;
  logic               locked_q, locked_d;
  logic               err_q, err_d;

  logic               rise, fall, same;
  logic [MATCH_W-1:0] match_new;

  assign rise      = s_q & ~s_d_q;
  assign fall      = ~s_q & s_d_q;
  assign same      = have_prev_q && (cnt_q == prev_p_q) && (hw_cur_q == prev_h_q);
  assign match_new = same ? (match_q + MATCH_W'(1)) : MATCH_W'(1);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hw_cur_d     = hw_cur_q;
    prev_p_d     = prev_p_q;
    prev_h_d     = prev_h_q;
    have_prev_d  = have_prev_q;
    match_d      = match_q;
    div_ratio_d  = div_ratio_q;
    high_width_d = high_width_q;
    odd_d        = odd_q;
    duty_d       = duty_q;
    locked_d     = locked_q;
    err_d        = 1'b0;

    case (state_q)
      MEAS, LOCKED: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        if (fall) hw_cur_d = cnt_q;
        if (rise) begin
          // cnt_q now holds the full period just completed
          cnt_d       = CNT_W'(1);
          prev_p_d    = cnt_q;
          prev_h_d    = hw_cur_q;
          have_prev_d = 1'b1;
          if (state_q == MEAS) begin
            match_d = match_new;
            if (match_new >= LOCK_TGT) begin
              state_d      = LOCKED;
              div_ratio_d  = cnt_q;
              high_width_d = hw_cur_q;
              odd_d        = cnt_q[0];
              duty_d       = (hw_cur_q == (cnt_q - hw_cur_q));
              locked_d     = 1'b1;
            end
          end else if (!same) begin
            state_d  = MEAS;
            match_d  = MATCH_W'(1);
            locked_d = 1'b0;
            err_d    = 1'b1;
          end
        end else if (cnt_q == CNT_MAX) begin
          state_d  = IDLE;
          locked_d = 1'b0;
          err_d    = 1'b1;
        end
      end
      default: begin
        if (rise) begin
          state_d     = MEAS;
          cnt_d       = CNT_W'(1);
          have_prev_d = 1'b0;
          match_d     = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      s_q          <= 1'b0;
      s_d_q        <= 1'b0;
      cnt_q        <= '0;
      hw_cur_q     <= '0;
      prev_p_q     <= '0;
      prev_h_q     <= '0;
      have_prev_q  <= 1'b0;
      match_q      <= '0;
      div_ratio_q  <= '0;
      high_width_q <= '0;
      odd_q        <= 1'b0;
      duty_q       <= 1'b0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_q          <= clk_in;
      s_d_q        <= s_q;
      cnt_q        <= cnt_d;
      hw_cur_q     <= hw_cur_d;
      prev_p_q     <= prev_p_d;
      prev_h_q     <= prev_h_d;
      have_prev_q  <= have_prev_d;
      match_q      <= match_d;
      div_ratio_q  <= div_ratio_d;
      high_width_q <= high_width_d;
      odd_q        <= odd_d;
      duty_q       <= duty_d;
      locked_q     <= locked_d;
      err_q        <= err_d;
    end
  end

  assign div_ratio  = div_ratio_q;
  assign high_width = high_width_q;
  assign odd_ratio  = odd_q;
  assign duty_even  = duty_q;
  assign locked     = locked_q;
  assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_detect.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_clk_div_detect: scoreboard bench for clk_div_detect. Rev 1.0          |
// +--------------------------------------------------------------------------+
module tb_clk_div_detect;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_in = 1'b0;
  logic [7:0] div_ratio, high_width;
  logic       odd_ratio, duty_even, locked, err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rise = 0;
  bit prev_locked = 1'b0;

  typedef struct {
    bit       is_err;
    int       cyc;
    bit [7:0] div;
    bit [7:0] hw;
    bit       odd;
    bit       duty;
    bit       lck;
  } exp_t;

  exp_t exp_q[$];

  clk_div_detect #(.CNT_W(8), .LOCK_N(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_in     (clk_in),
    .div_ratio  (div_ratio),
    .high_width (high_width),
    .odd_ratio  (odd_ratio),
    .duty_even  (duty_even),
    .locked     (locked),
    .err        (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_ev(input bit is_err, input int c, input int dv, input int hw,
                           input bit odd, input bit duty, input bit lck);
    exp_t e;
    e.is_err = is_err; e.cyc = c; e.div = 8'(dv); e.hw = 8'(hw);
    e.odd = odd; e.duty = duty; e.lck = lck;
    exp_q.push_back(e);
  endtask

  // One clk_in period: h cycles high then l low; an optional event is expected
  // two clk edges after the rise that starts this period.
  task automatic period(input int h, input int l, input bit push, input bit is_err,
                        input int dv, input int hw, input bit odd, input bit duty,
                        input bit lck);
    for (int i = 0; i < h; i++) begin
      @(posedge clk); #1;
      clk_in = 1'b1;
      if (i == 0) begin
        last_rise = cyc;
        if (push) expect_ev(is_err, cyc + 2, dv, hw, odd, duty, lck);
      end
    end
    for (int i = 0; i < l; i++) begin
      @(posedge clk); #1;
      clk_in = 1'b0;
    end
  endtask

  task automatic plain(input int h, input int l);
    period(h, l, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if (div_ratio !== 8'd0 || high_width !== 8'd0 || odd_ratio !== 1'b0 ||
        duty_even !== 1'b0 || locked !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL %s: got div=%0d hw=%0d odd=%0b duty=%0b locked=%0b err=%0b, want all 0",
               tag, div_ratio, high_width, odd_ratio, duty_even, locked, err);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    clk_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: an output event is an err pulse or a rising edge of locked.
  always @(negedge clk) begin
    if (rst_n && (err || (locked && !prev_locked))) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: cyc=%0d err=%0b locked=%0b div=%0d hw=%0d",
                 cyc, err, locked, div_ratio, high_width);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (err !== e.is_err || cyc != e.cyc || div_ratio !== e.div || high_width !== e.hw ||
            odd_ratio !== e.odd || duty_even !== e.duty || locked !== e.lck) begin
          errors++;
          $display("FAIL event: got err=%0b cyc=%0d div=%0d hw=%0d odd=%0b duty=%0b locked=%0b; want err=%0b cyc=%0d div=%0d hw=%0d odd=%0b duty=%0b locked=%0b",
                   err, cyc, div_ratio, high_width, odd_ratio, duty_even, locked,
                   e.is_err, e.cyc, e.div, e.hw, e.odd, e.duty, e.lck);
        end
      end
    end
    prev_locked = locked;
  end

  initial begin
    // Reset values
    #2 check_zero("reset_values");
    do_reset();
    check_zero("after_release");

    // DIV=10, 5/5: lock on the third rise
    plain(5, 5);
    plain(5, 5);
    period(5, 5, 1'b1, 1'b0, 10, 5, 1'b0, 1'b1, 1'b1);
    plain(5, 5);

    // Hold low: timeout 257 edges after the last rise, values held
    expect_ev(1'b1, last_rise + 257, 10, 5, 1'b0, 1'b1, 1'b0);
    repeat (300) @(posedge clk);
    #1;
    checks++;
    if (locked !== 1'b0 || div_ratio !== 8'd10 || high_width !== 8'd5) begin
      errors++;
      $display("FAIL timeout_hold: got locked=%0b div=%0d hw=%0d, want 0 10 5",
               locked, div_ratio, high_width);
    end

    // Relock at 10, then switch to 3/3
    plain(5, 5);
    plain(5, 5);
    period(5, 5, 1'b1, 1'b0, 10, 5, 1'b0, 1'b1, 1'b1);
    plain(5, 5);
    plain(3, 3);
    period(3, 3, 1'b1, 1'b1, 10, 5, 1'b0, 1'b1, 1'b0);
    period(3, 3, 1'b1, 1'b0, 6, 3, 1'b0, 1'b1, 1'b1);
    plain(3, 3);
    checks++;
    if (locked !== 1'b1 || div_ratio !== 8'd6) begin
      errors++;
      $display("FAIL relock_6: got locked=%0b div=%0d, want 1 6", locked, div_ratio);
    end

    // Asynchronous reset while locked
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1 check_zero("async_reset");
    clk_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_zero("after_async_release");
    plain(5, 5);
    plain(5, 5);
    period(5, 5, 1'b1, 1'b0, 10, 5, 1'b0, 1'b1, 1'b1);
    plain(5, 5);

    // Minimum period: toggle every clk
    do_reset();
    plain(1, 1);
    plain(1, 1);
    period(1, 1, 1'b1, 1'b0, 2, 1, 1'b0, 1'b1, 1'b1);
    plain(1, 1);
    plain(1, 1);

    // Asymmetric 3 high / 4 low
    do_reset();
    plain(3, 4);
    plain(3, 4);
    period(3, 4, 1'b1, 1'b0, 7, 3, 1'b1, 1'b0, 1'b1);
    plain(3, 4);
    repeat (4) @(posedge clk);

    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: got %0d unconsumed, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
